operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 10 +
 rtl/operand_fetch_if.sv | 61 ++++++
 rtl/operand_fetch_scoreboard.sv | 60 ++++++
 rtl/operand_fetch.sv | 97 +++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared CPU constants and types used by operand fetch and the register file.
package operand_fetch_pkg;

    localparam int unsigned CPU_WORD_SIZE = 18;
    localparam int unsigned CPU_REG_COUNT = 8;
    localparam int unsigned CPU_REG_AW    = 3;

    typedef logic [CPU_REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: decoded-instruction input, register-file read port,
// writeback snoop, registered output stage and scoreboard visibility.
interface operand_fetch_if
    import operand_fetch_pkg::*;
#(
    parameter int unsigned WORD_SIZE = CPU_WORD_SIZE,
    parameter int unsigned REG_COUNT = CPU_REG_COUNT
) ();

    logic                 in_valid;
    logic                 in_ready;
    reg_addr_t            in_src0;
    reg_addr_t            in_src1;
    logic                 in_use0;
    logic                 in_use1;
    reg_addr_t            in_dst;
    logic                 in_dst_we;

    reg_addr_t            rf_addr0;
    reg_addr_t            rf_addr1;
    logic [WORD_SIZE-1:0] rf_data0;
    logic [WORD_SIZE-1:0] rf_data1;

    logic                 wb_valid;
    reg_addr_t            wb_addr;
    logic [WORD_SIZE-1:0] wb_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_op0;
    logic [WORD_SIZE-1:0] out_op1;
    reg_addr_t            out_dst;
    logic                 out_dst_we;

    logic [REG_COUNT-1:0] pending;

    // Environment side: decoder, register file, writeback and consumer.
    modport master (
        output in_valid, in_src0, in_src1, in_use0, in_use1, in_dst, in_dst_we,
        input  in_ready,
        input  rf_addr0, rf_addr1,
        output rf_data0, rf_data1,
        output wb_valid, wb_addr, wb_data,
        input  out_valid, out_op0, out_op1, out_dst, out_dst_we,
        output out_ready,
        input  pending
    );

    // Operand-fetch stage side.
    modport slave (
        input  in_valid, in_src0, in_src1, in_use0, in_use1, in_dst, in_dst_we,
        output in_ready,
        output rf_addr0, rf_addr1,
        input  rf_data0, rf_data1,
        input  wb_valid, wb_addr, wb_data,
        output out_valid, out_op0, out_op1, out_dst, out_dst_we,
        input  out_ready,
        output pending
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register with an issued, unretired
// write, plus hazard lookup for two sources and one destination.
module op_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int unsigned REG_COUNT = CPU_REG_COUNT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_set,
    input  reg_addr_t            i_set_addr,
    input  logic                 i_clr,
    input  reg_addr_t            i_clr_addr,
    input  reg_addr_t            i_src0,
    input  logic                 i_use0,
    input  reg_addr_t            i_src1,
    input  logic                 i_use1,
    input  reg_addr_t            i_dst,
    input  logic                 i_dst_we,
    output logic                 o_haz_src0,
    output logic                 o_haz_src1,
    output logic                 o_haz_dst,
    output logic [REG_COUNT-1:0] o_pending
);

    logic [REG_COUNT-1:0] r_pending;
    logic [REG_COUNT-1:0] w_pending_next;

    // A writeback in the same cycle retires the pending write, so it
    // resolves the hazard it would otherwise cause.
    assign o_haz_src0 = i_use0 && r_pending[i_src0]
                        && !(i_clr && (i_clr_addr == i_src0));
    assign o_haz_src1 = i_use1 && r_pending[i_src1]
                        && !(i_clr && (i_clr_addr == i_src1));
    assign o_haz_dst  = i_dst_we && r_pending[i_dst]
                        && !(i_clr && (i_clr_addr == i_dst));

    assign o_pending = r_pending;

    // Next pending vector: clear applied first so a same-register set wins.
    always_comb begin
        w_pending_next = r_pending;
        if (i_clr) begin
            w_pending_next[i_clr_addr] = 1'b0;
        end
        if (i_set) begin
            w_pending_next[i_set_addr] = 1'b1;
        end
    end

    // Pending register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources with writeback bypass, stalls on RAW/WAW
// hazards against the scoreboard, and registers operands for the next stage.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned WORD_SIZE = CPU_WORD_SIZE,
    parameter int unsigned REG_COUNT = CPU_REG_COUNT
) (
    input  logic              clock,
    input  logic              reset,
    operand_fetch_if.slave    bus
);

    logic                 w_haz_src0;
    logic                 w_haz_src1;
    logic                 w_haz_dst;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [WORD_SIZE-1:0] w_op0;
    logic [WORD_SIZE-1:0] w_op1;
    logic [REG_COUNT-1:0] w_pending;

    logic                 r_out_valid;
    logic [WORD_SIZE-1:0] r_out_op0;
    logic [WORD_SIZE-1:0] r_out_op1;
    reg_addr_t            r_out_dst;
    logic                 r_out_dst_we;

    op_scoreboard #(
        .REG_COUNT (REG_COUNT)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .i_set      (w_accept && bus.in_dst_we),
        .i_set_addr (bus.in_dst),
        .i_clr      (bus.wb_valid),
        .i_clr_addr (bus.wb_addr),
        .i_src0     (bus.in_src0),
        .i_use0     (bus.in_use0),
        .i_src1     (bus.in_src1),
        .i_use1     (bus.in_use1),
        .i_dst      (bus.in_dst),
        .i_dst_we   (bus.in_dst_we),
        .o_haz_src0 (w_haz_src0),
        .o_haz_src1 (w_haz_src1),
        .o_haz_dst  (w_haz_dst),
        .o_pending  (w_pending)
    );

    assign bus.rf_addr0 = bus.in_src0;
    assign bus.rf_addr1 = bus.in_src1;

    assign w_in_ready = !reset && !w_haz_src0 && !w_haz_src1 && !w_haz_dst
                        && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Operand select: bypass the writeback only for a source actually read,
    // so unused sources stay the plain register-file value.
    always_comb begin
        w_op0 = bus.rf_data0;
        w_op1 = bus.rf_data1;
        if (bus.in_use0 && bus.wb_valid && (bus.wb_addr == bus.in_src0)) begin
            w_op0 = bus.wb_data;
        end
        if (bus.in_use1 && bus.wb_valid && (bus.wb_addr == bus.in_src1)) begin
            w_op1 = bus.wb_data;
        end
    end

    // Output stage: load on acceptance, drop valid once consumed, hold on stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_op0    <= '0;
            r_out_op1    <= '0;
            r_out_dst    <= '0;
            r_out_dst_we <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_op0    <= w_op0;
            r_out_op1    <= w_op1;
            r_out_dst    <= bus.in_dst;
            r_out_dst_we <= bus.in_dst_we;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_op0    = r_out_op0;
    assign bus.out_op1    = r_out_op1;
    assign bus.out_dst    = r_out_dst;
    assign bus.out_dst_we = r_out_dst_we;
    assign bus.pending    = w_pending;

endmodule
